// File: rtl/pwm_capture_avalon.sv
// Avalon-MM PWM capture: measures high time and period of coe_pwm_in in csi_clk cycles.
// Reads return registered data one cycle after the strobe; the slave never stalls the bus.
module pwm_capture_avalon #(
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic        csi_clk,
  input  logic        rsi_rst_n,
  input  logic        avs_s0_chip_select,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [1:0]  avs_s0_address,
  input  logic [3:0]  avs_s0_byteenable,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        ins_irq_irq,
  input  logic        coe_pwm_in
);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] high_cap_q, high_cap_d;
  logic [31:0] high_time_q, period_q;
  logic        ctrl_en_q, ctrl_irq_en_q;
  logic        valid_q, overrun_q, timeout_q;
  logic        sync1_q, sync2_q, dly_q;
  logic        rise, fall, capture, expire;
  logic        wr_ctrl, wr_stat;
  logic [31:0] rd_dat;
  logic        unused_ok;

  assign unused_ok = ^{avs_s0_byteenable[3:1], avs_s0_writedata[31:3]};
  assign wr_ctrl = avs_s0_chip_select & avs_s0_write & avs_s0_byteenable[0]
                   & (avs_s0_address == 2'd2);
  assign wr_stat = avs_s0_chip_select & avs_s0_write & avs_s0_byteenable[0]
                   & (avs_s0_address == 2'd3);
  assign rise = sync2_q & ~dly_q;
  assign fall = ~sync2_q & dly_q;

  always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
    if (!rsi_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= coe_pwm_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
    if (!rsi_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_cap_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cap_q <= high_cap_d;
    end
  end

  // cnt counts clocks since the last measured rising edge; an edge beats the timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cap_d = high_cap_q;
    capture    = 1'b0;
    expire     = 1'b0;
    if (!ctrl_en_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_d   = 32'd1;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            high_cap_d = cnt_q;
            cnt_d      = cnt_q + 32'd1;
            state_d    = LOW;
          end else if (cnt_q >= TIMEOUT) begin
            expire  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        LOW: begin
          if (rise) begin
            capture = 1'b1;
            cnt_d   = 32'd1;
            state_d = HIGH;
          end else if (cnt_q >= TIMEOUT) begin
            expire  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Flag sets take priority over a simultaneous write-1-to-clear.
  always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
    if (!rsi_rst_n) begin
      high_time_q   <= '0;
      period_q      <= '0;
      ctrl_en_q     <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      if (capture) begin
        high_time_q <= high_cap_q;
        period_q    <= cnt_q;
      end
      if (wr_ctrl) begin
        ctrl_en_q     <= avs_s0_writedata[0];
        ctrl_irq_en_q <= avs_s0_writedata[1];
      end
      valid_q   <= capture | (valid_q & ~(wr_stat & avs_s0_writedata[0]));
      overrun_q <= (capture & valid_q) | (overrun_q & ~(wr_stat & avs_s0_writedata[1]));
      timeout_q <= expire | (timeout_q & ~(wr_stat & avs_s0_writedata[2]));
    end
  end

  always_comb begin
    rd_dat = '0;
    case (avs_s0_address)
      2'd0:    rd_dat = high_time_q;
      2'd1:    rd_dat = period_q;
      2'd2:    rd_dat = {30'd0, ctrl_irq_en_q, ctrl_en_q};
      default: rd_dat = {28'd0, sync2_q, timeout_q, overrun_q, valid_q};
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
    if (!rsi_rst_n) begin
      avs_s0_readdata <= '0;
    end else if (avs_s0_chip_select && avs_s0_read) begin
      avs_s0_readdata <= rd_dat;
    end
  end

  assign ins_irq_irq = ctrl_irq_en_q & (valid_q | timeout_q);
endmodule

// File: tb/tb_pwm_capture_avalon.sv
// Bench for pwm_capture_avalon: directed PWM waveforms and bus accesses,
// checked every cycle against a timestamp-based model plus literal expectations.
module tb_pwm_capture_avalon;
  localparam int unsigned TO = 1000;

  logic        csi_clk = 1'b0;
  logic        rsi_rst_n = 1'b0;
  logic        avs_s0_chip_select = 1'b0;
  logic        avs_s0_read = 1'b0;
  logic        avs_s0_write = 1'b0;
  logic [1:0]  avs_s0_address = 2'd0;
  logic [3:0]  avs_s0_byteenable = 4'hF;
  logic [31:0] avs_s0_writedata = 32'd0;
  logic [31:0] avs_s0_readdata;
  logic        ins_irq_irq;
  logic        coe_pwm_in;

  int checks = 0;
  int failures = 0;

  pwm_capture_avalon #(.TIMEOUT(TO)) dut (
    .csi_clk            (csi_clk),
    .rsi_rst_n          (rsi_rst_n),
    .avs_s0_chip_select (avs_s0_chip_select),
    .avs_s0_read        (avs_s0_read),
    .avs_s0_write       (avs_s0_write),
    .avs_s0_address     (avs_s0_address),
    .avs_s0_byteenable  (avs_s0_byteenable),
    .avs_s0_writedata   (avs_s0_writedata),
    .avs_s0_readdata    (avs_s0_readdata),
    .ins_irq_irq        (ins_irq_irq),
    .coe_pwm_in         (coe_pwm_in)
  );

  always #5 csi_clk = ~csi_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pin generator: a free-running hi/lo waveform, or a static level; updates just after posedge.
  int wave_hi = 30;
  int wave_lo = 70;
  bit wave_on = 1'b0;
  bit wave_lvl = 1'b0;
  initial begin
    int ph;
    bit prev_on;
    ph = 0;
    prev_on = 1'b0;
    coe_pwm_in = 1'b0;
    forever begin
      @(posedge csi_clk);
      #1;
      if (wave_on) begin
        if (!prev_on) ph = 0;
        else ph = (ph + 1) % (wave_hi + wave_lo);
        coe_pwm_in = (ph < wave_hi);
      end else begin
        coe_pwm_in = wave_lvl;
      end
      prev_on = wave_on;
    end
  end

  // Model: widths are differences of edge timestamps on the 2-clock-delayed pin.
  logic [31:0] m_ht = 0, m_per = 0, m_hc = 0, exp_rd = 0;
  bit          m_en = 0, m_ie = 0, m_v = 0, m_o = 0, m_t = 0;
  bit [2:0]    hist = 0;
  int          phase = 0;
  longint      cyc = 0, t_rise = 0;
  initial begin
    bit lvl, rs, fl, cap, tmo, wr_ok, v_old;
    forever begin
      @(posedge csi_clk or negedge rsi_rst_n);
      if (!rsi_rst_n) begin
        m_ht = 0; m_per = 0; m_hc = 0; exp_rd = 0;
        m_en = 0; m_ie = 0; m_v = 0; m_o = 0; m_t = 0;
        hist = 0; phase = 0; t_rise = 0;
      end else begin
        lvl = hist[1];
        rs  = lvl & ~hist[2];
        fl  = ~lvl & hist[2];
        if (avs_s0_chip_select && avs_s0_read) begin
          case (avs_s0_address)
            2'd0:    exp_rd = m_ht;
            2'd1:    exp_rd = m_per;
            2'd2:    exp_rd = {30'd0, m_ie, m_en};
            default: exp_rd = {28'd0, lvl, m_t, m_o, m_v};
          endcase
        end
        cap = 0;
        tmo = 0;
        if (!m_en) phase = 0;
        else begin
          case (phase)
            0: phase = 1;
            1: if (rs) begin t_rise = cyc; phase = 2; end
            2: if (fl) begin m_hc = 32'(cyc - t_rise); phase = 3; end
               else if (cyc - t_rise >= longint'(TO)) begin tmo = 1; phase = 1; end
            default: if (rs) begin
                       cap = 1; m_per = 32'(cyc - t_rise); m_ht = m_hc;
                       t_rise = cyc; phase = 2;
                     end else if (cyc - t_rise >= longint'(TO)) begin tmo = 1; phase = 1; end
          endcase
        end
        wr_ok = avs_s0_chip_select & avs_s0_write & avs_s0_byteenable[0];
        v_old = m_v;
        if (wr_ok && avs_s0_address == 2'd3) begin
          if (avs_s0_writedata[0]) m_v = 0;
          if (avs_s0_writedata[1]) m_o = 0;
          if (avs_s0_writedata[2]) m_t = 0;
        end
        if (cap) begin
          m_v = 1;
          if (v_old) m_o = 1;
        end
        if (tmo) m_t = 1;
        if (wr_ok && avs_s0_address == 2'd2) begin
          m_en = avs_s0_writedata[0];
          m_ie = avs_s0_writedata[1];
        end
      end
      hist = {hist[1:0], coe_pwm_in};
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge csi_clk);
      check("model_readdata", avs_s0_readdata, exp_rd);
      check("model_irq", {31'd0, ins_irq_irq}, {31'd0, m_ie & (m_v | m_t)});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge csi_clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge csi_clk);
    avs_s0_chip_select = 1'b1; avs_s0_read = 1'b1; avs_s0_address = a;
    @(negedge csi_clk);
    avs_s0_chip_select = 1'b0; avs_s0_read = 1'b0;
    d = avs_s0_readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v, input logic [3:0] be);
    @(negedge csi_clk);
    avs_s0_chip_select = 1'b1; avs_s0_write = 1'b1; avs_s0_address = a;
    avs_s0_writedata = v; avs_s0_byteenable = be;
    @(negedge csi_clk);
    avs_s0_chip_select = 1'b0; avs_s0_write = 1'b0; avs_s0_byteenable = 4'hF;
  endtask

  initial begin
    logic [31:0] d;
    @(posedge csi_clk); #2 rsi_rst_n = 1'b0;
    repeat (3) @(posedge csi_clk);
    #2 rsi_rst_n = 1'b1;

    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check("reset_read", d, 32'd0);
    end
    check("reset_irq", {31'd0, ins_irq_irq}, 32'd0);

    // 30/70 waveform, first capture after the second rise
    wr(2'd2, 32'h1, 4'hF);
    wave_hi = 30; wave_lo = 70; wave_on = 1'b1;
    wait_cyc(150);
    rd(2'd0, d); check("high_time_30", d, 32'd30);
    rd(2'd1, d); check("period_100", d, 32'd100);
    rd(2'd3, d); check("status_valid", d & 32'h7, 32'h1);
    wr(2'd2, 32'h0, 4'hE);
    rd(2'd2, d); check("ctrl_be0_ignored", d, 32'h1);
    wr(2'd0, 32'hFFFF, 4'hF);
    rd(2'd0, d); check("high_time_ro", d, 32'd30);

    // two more captures without clearing raise overrun
    wait_cyc(200);
    rd(2'd3, d); check("status_overrun", d & 32'h3, 32'h3);
    wr(2'd3, 32'h3, 4'hF);
    rd(2'd3, d); check("status_w1c", d & 32'h3, 32'h0);
    wait_cyc(100);
    rd(2'd3, d); check("status_valid_only", d & 32'h7, 32'h1);

    // timeout while held high
    wr(2'd2, 32'h0, 4'hF);
    wave_on = 1'b0; wave_lvl = 1'b0;
    wait_cyc(10);
    wr(2'd2, 32'h3, 4'hF);
    wr(2'd3, 32'h7, 4'hF);
    check("irq_cleared", {31'd0, ins_irq_irq}, 32'd0);
    wave_lvl = 1'b1;
    wait_cyc(2000);
    rd(2'd3, d); check("status_timeout", d & 32'h7, 32'h4);
    check("irq_timeout", {31'd0, ins_irq_irq}, 32'd1);
    rd(2'd0, d); check("timeout_ht_kept", d, 32'd30);
    rd(2'd1, d); check("timeout_per_kept", d, 32'd100);
    wr(2'd3, 32'h4, 4'hF);
    check("irq_deassert", {31'd0, ins_irq_irq}, 32'd0);

    // enable while input is high: partial pulse ignored
    wr(2'd2, 32'h0, 4'hF);
    wait_cyc(10);
    wr(2'd2, 32'h3, 4'hF);
    wr(2'd3, 32'h7, 4'hF);
    wave_hi = 50; wave_lo = 50; wave_on = 1'b1;
    wait_cyc(150);
    rd(2'd3, d); check("partial_no_capture", d & 32'h1, 32'h0);
    wait_cyc(100);
    rd(2'd0, d); check("high_time_50", d, 32'd50);
    rd(2'd1, d); check("period_100b", d, 32'd100);
    rd(2'd3, d); check("status_50", d & 32'h7, 32'h1);
    check("irq_valid", {31'd0, ins_irq_irq}, 32'd1);

    // W1C of valid landing on the capture edge
    wave_on = 1'b0; wave_lvl = 1'b0;
    wr(2'd2, 32'h0, 4'hF);
    wait_cyc(5);
    wr(2'd2, 32'h1, 4'hF);
    wr(2'd3, 32'h7, 4'hF);
    wait_cyc(5);
    @(negedge csi_clk); wave_lvl = 1'b1;
    wait_cyc(20); wave_lvl = 1'b0;
    wait_cyc(20); wave_lvl = 1'b1;
    wait_cyc(2);
    wr(2'd3, 32'h1, 4'hF);
    rd(2'd3, d); check("w1c_set_wins", d & 32'h7, 32'h1);
    rd(2'd0, d); check("high_time_20", d, 32'd20);
    rd(2'd1, d); check("period_40", d, 32'd40);

    // disable mid-high: nothing captured, registers retained
    wait_cyc(5);
    wr(2'd2, 32'h0, 4'hF);
    wr(2'd3, 32'h7, 4'hF);
    wave_lvl = 1'b0; wait_cyc(20);
    wave_lvl = 1'b1; wait_cyc(20);
    wave_lvl = 1'b0; wait_cyc(20);
    wave_lvl = 1'b1; wait_cyc(20);
    rd(2'd3, d); check("disabled_no_flags", d & 32'h7, 32'h0);
    rd(2'd0, d); check("disabled_ht_kept", d, 32'd20);
    rd(2'd1, d); check("disabled_per_kept", d, 32'd40);

    // reset in the middle of operation
    wr(2'd2, 32'h1, 4'hF);
    wave_hi = 30; wave_lo = 70; wave_on = 1'b1;
    wait_cyc(150);
    @(posedge csi_clk); #2 rsi_rst_n = 1'b0;
    repeat (2) @(posedge csi_clk);
    #2 rsi_rst_n = 1'b1;
    rd(2'd0, d); check("rst_ht", d, 32'd0);
    rd(2'd2, d); check("rst_ctrl", d, 32'd0);
    rd(2'd3, d); check("rst_flags", d & 32'h7, 32'h0);
    check("rst_irq", {31'd0, ins_irq_irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_capture_avalon.md
# pwm_capture_avalon

Avalon-MM slave that measures an incoming PWM waveform on `coe_pwm_in`, reporting high time and period in `csi_clk` cycles. It is the receive-side counterpart of the team's PWM generator peripheral and sits on the same Qsys Avalon-MM bus. It provides sticky status flags and a level-sensitive interrupt.

## Interface
Parameters:
- `TIMEOUT`, default 50_000_000: counter value at which an in-progress measurement is abandoned. Must be ≥ 2.

Ports:
- `csi_clk` input, 1 bit: clock.
- `rsi_rst_n` input, 1 bit: reset, asynchronous, active-low.
- `avs_s0_chip_select` input, 1 bit: slave select.
- `avs_s0_read` input, 1 bit: read strobe.
- `avs_s0_write` input, 1 bit: write strobe.
- `avs_s0_address` input, 2 bits: word address.
- `avs_s0_byteenable` input, 4 bits: byte lanes. Only lane 0 is significant for writes.
- `avs_s0_writedata` input, 32 bits: write data.
- `avs_s0_readdata` output, 32 bits: registered read data.
- `ins_irq_irq` output, 1 bit: interrupt, active-high, level.
- `coe_pwm_in` input, 1 bit: asynchronous PWM input.

## Operation
Register map:
- Address 0, HIGH_TIME (read-only): last captured high time, in clocks.
- Address 1, PERIOD (read-only): last captured period, rising edge to rising edge, in clocks.
- Address 2, CONTROL (read/write):
  - bit0 `enable`
  - bit1 `irq_en`
  - other bits read as 0.
- Address 3, STATUS:
  - bit0 `valid` (write-1-to-clear)
  - bit1 `overrun` (write-1-to-clear)
  - bit2 `timeout` (write-1-to-clear)
  - bit3 `level`: synchronized input, read-only
  - other bits read as 0.

Register access rules:
- Writes occur when `chip_select & write`. A write to CONTROL or STATUS takes effect only if `byteenable[0]=1`. Writes to addresses 0 and 1 are ignored.
- Reads ignore byteenable. All 32 bits are returned.

Input conditioning:
- `coe_pwm_in` passes through a 2-flop synchronizer, then one delay flop.
- `rise` = synchronized input 1 and delayed input 0.
- `fall` = synchronized input 0 and delayed input 1.

State machine (32-bit counter `cnt`, holding register `high_cap`):
- **IDLE**: `cnt`=0.
  - Enters IDLE whenever `enable`=0, from any state, on the next clock.
  - `enable`=1 → WAIT_RISE.
- **WAIT_RISE**: on `rise`, `cnt`←1 and go to HIGH.
  - A partial pulse present at enable time is never measured.
- **HIGH**: `cnt`←`cnt`+1 each cycle.
  - On `fall`: `high_cap`←`cnt`, go to LOW.
- **LOW**: `cnt`←`cnt`+1 each cycle.
  - On `rise` (capture): PERIOD←`cnt`, HIGH_TIME←`high_cap`, set `valid`; set `overrun` if `valid` was already 1; `cnt`←1; go to HIGH.
- **Timeout**: in HIGH or LOW, if `cnt`≥`TIMEOUT` and no edge occurs this cycle, set `timeout`, `cnt`←0, go to WAIT_RISE. HIGH_TIME and PERIOD are unchanged.
- An edge and the timeout threshold in the same cycle: the edge wins.

Other rules:
- Disabling mid-measurement discards the partial measurement. Captured registers and flags are retained.
- A W1C write and a flag set in the same cycle: the set wins.
- `ins_irq_irq` = `irq_en & (valid | timeout)`, combinational from registers.
- Minimum measurable: 1 clock high and 1 clock low (synchronized), i.e. period ≥ 2.

## Timing
- Reset values:
  - `avs_s0_readdata` = 0, `ins_irq_irq` = 0.
  - HIGH_TIME, PERIOD, CONTROL, STATUS flags, `cnt`, `high_cap`, synchronizer flops all 0.
  - State = IDLE.
- Read latency: exactly 1 cycle. `readdata` is loaded on the clock edge where `chip_select & read`, and holds otherwise.
- Write latency: a register write is visible to a read issued in the following cycle.
- Pin-to-detect latency: 3 clocks, identical for both edges, so measured widths equal input widths in clocks.
- Capture timing: `valid` and updated HIGH_TIME/PERIOD are visible the cycle after the capture `rise`. `ins_irq_irq` asserts in that same cycle.
- Reset asserted mid-operation: immediately returns all state to the reset values.

## Test plan
- Reset, then read all four addresses → all read 0; `ins_irq_irq`=0.
- Write CONTROL=0x1, drive 30 clocks high / 70 clocks low repeatedly → after the second rising edge, HIGH_TIME=30, PERIOD=100, STATUS=0x1 (plus bit3 per level).
- Let 2 more periods pass without clearing → STATUS bits0,1=1. Write STATUS=0x3 → both clear. Next period sets only bit0.
- Bench `TIMEOUT`=1000, CONTROL=0x3, hold input high for 2000 clocks → STATUS bit2=1, `ins_irq_irq`=1, HIGH_TIME/PERIOD unchanged. Write 0x4 to STATUS → irq deasserts.
- Input high when enable is written, 50/50-clock waveform → first partial pulse ignored; first capture gives HIGH_TIME=50, PERIOD=100.
- W1C of `valid` in the capture cycle → `valid` stays 1. Clear `enable` mid-HIGH → no capture, registers retained.
